// File: rtl/btn_conditioner_if.sv
// Button conditioner bus: raw pins in, debounced levels and edge strobes out.
// master = board/bench side driving the raw pins, slave = the conditioner.
interface btn_conditioner_if #(
    parameter int NUM_BTNS = 5
);
    logic [NUM_BTNS-1:0] btn_raw;
    logic [NUM_BTNS-1:0] btn_level;
    logic [NUM_BTNS-1:0] btn_rise;
    logic [NUM_BTNS-1:0] btn_fall;

    modport master (output btn_raw, input btn_level, input btn_rise, input btn_fall);
    modport slave  (input btn_raw, output btn_level, output btn_rise, output btn_fall);
endinterface

// File: rtl/btn_conditioner.sv
// btn_conditioner: per-button metastability synchroniser, saturating debounce
// FSM, and registered level plus one-cycle rise/fall strobes.
// Bit order of the bus is {btnu, btnl, btnc, btnr, btnd}; bit0 = btnd.
// Optional feature macro: BTN_AUTOREPEAT_EN adds a hold-to-repeat rise strobe
// on channels selected by REPEAT_MASK; when undefined no repeat logic exists.
module btn_conditioner #(
    parameter int                  NUM_BTNS        = 5,
    parameter int                  SYNC_STAGES     = 2,
    parameter int                  DEBOUNCE_CYCLES = 500000,
    parameter int                  REPEAT_DELAY    = 25000000,
    parameter int                  REPEAT_PERIOD   = 5000000,
    parameter logic [NUM_BTNS-1:0] REPEAT_MASK     = 5'b00001
) (
    input  logic             clk,
    input  logic             rst_n,
    btn_conditioner_if.slave bus
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] CNT_ZERO = {CW{1'b0}};
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);
    localparam logic [CW-1:0] CNT_MAX  = CW'(DEBOUNCE_CYCLES);

    typedef enum logic [1:0] {
        IDLE_LO = 2'd0,
        CHK_HI  = 2'd1,
        HELD_HI = 2'd2,
        CHK_LO  = 2'd3
    } state_e;

    logic [NUM_BTNS-1:0] level_v_s;
    logic [NUM_BTNS-1:0] rise_v_s;
    logic [NUM_BTNS-1:0] fall_v_s;

    for (genvar i = 0; i < NUM_BTNS; i++) begin : g_ch
        logic [SYNC_STAGES-1:0] sync_r;
        logic                   s_s;
        state_e                 state_r, state_s;
        logic [CW-1:0]          cnt_r, cnt_s;
        logic                   level_r, level_s;
        logic                   rise_r, rise_s;
        logic                   fall_r, fall_s;
        logic                   rep_fire_s;

        // Shift the asynchronous pin through the synchroniser chain.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                sync_r <= {SYNC_STAGES{1'b0}};
            end else begin
                sync_r <= {sync_r[SYNC_STAGES-2:0], bus.btn_raw[i]};
            end
        end

        assign s_s = sync_r[SYNC_STAGES-1];

        // Debounce state, counter and registered outputs.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                state_r <= IDLE_LO;
                cnt_r   <= CNT_ZERO;
                level_r <= 1'b0;
                rise_r  <= 1'b0;
                fall_r  <= 1'b0;
            end else begin
                state_r <= state_s;
                cnt_r   <= cnt_s;
                level_r <= level_s;
                rise_r  <= rise_s;
                fall_r  <= fall_s;
            end
        end

        // Next-state: count consecutive mismatching samples, accept at the limit.
        always_comb begin
            state_s = state_r;
            cnt_s   = cnt_r;
            level_s = level_r;
            rise_s  = 1'b0;
            fall_s  = 1'b0;
            case (state_r)
                IDLE_LO: begin
                    level_s = 1'b0;
                    if (s_s) begin
                        if (DEBOUNCE_CYCLES == 1) begin
                            state_s = HELD_HI;
                            cnt_s   = CNT_ZERO;
                            level_s = 1'b1;
                            rise_s  = 1'b1;
                        end else begin
                            state_s = CHK_HI;
                            cnt_s   = CNT_ONE;
                        end
                    end else begin
                        cnt_s = CNT_ZERO;
                    end
                end
                CHK_HI: begin
                    if (!s_s) begin
                        state_s = IDLE_LO;
                        cnt_s   = CNT_ZERO;
                    end else if (cnt_r == CNT_LAST) begin
                        state_s = HELD_HI;
                        cnt_s   = CNT_ZERO;
                        level_s = 1'b1;
                        rise_s  = 1'b1;
                    end else if (cnt_r != CNT_MAX) begin
                        cnt_s = cnt_r + CNT_ONE;
                    end else begin
                        cnt_s = cnt_r;
                    end
                end
                HELD_HI: begin
                    level_s = 1'b1;
                    if (!s_s) begin
                        if (DEBOUNCE_CYCLES == 1) begin
                            state_s = IDLE_LO;
                            cnt_s   = CNT_ZERO;
                            level_s = 1'b0;
                            fall_s  = 1'b1;
                        end else begin
                            state_s = CHK_LO;
                            cnt_s   = CNT_ONE;
                        end
                    end else begin
                        cnt_s = CNT_ZERO;
                    end
                end
                CHK_LO: begin
                    if (s_s) begin
                        state_s = HELD_HI;
                        cnt_s   = CNT_ZERO;
                    end else if (cnt_r == CNT_LAST) begin
                        state_s = IDLE_LO;
                        cnt_s   = CNT_ZERO;
                        level_s = 1'b0;
                        fall_s  = 1'b1;
                    end else if (cnt_r != CNT_MAX) begin
                        cnt_s = cnt_r + CNT_ONE;
                    end else begin
                        cnt_s = cnt_r;
                    end
                end
                default: begin
                    state_s = IDLE_LO;
                    cnt_s   = CNT_ZERO;
                    level_s = 1'b0;
                end
            endcase
            rise_s = rise_s | rep_fire_s;
        end

`ifdef BTN_AUTOREPEAT_EN
        if (REPEAT_MASK[i]) begin : g_rep
            localparam int RMAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
            localparam int RW   = $clog2(RMAX + 1);
            localparam logic [RW-1:0] REP_ZERO     = {RW{1'b0}};
            localparam logic [RW-1:0] REP_ONE      = RW'(1);
            localparam logic [RW-1:0] REP_DLY_LAST = RW'(REPEAT_DELAY - 1);
            localparam logic [RW-1:0] REP_PER_LAST = RW'(REPEAT_PERIOD - 1);

            logic [RW-1:0] rep_cnt_r, rep_cnt_s;
            logic          rep_armed_r, rep_armed_s;
            logic          fire_s;

            // Repeat counter and first-delay-elapsed flag.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    rep_cnt_r   <= REP_ZERO;
                    rep_armed_r <= 1'b0;
                end else begin
                    rep_cnt_r   <= rep_cnt_s;
                    rep_armed_r <= rep_armed_s;
                end
            end

            // Count while staying in HELD_HI; any other state restarts the delay.
            always_comb begin
                rep_cnt_s   = REP_ZERO;
                rep_armed_s = 1'b0;
                fire_s      = 1'b0;
                if ((state_r == HELD_HI) && s_s) begin
                    rep_armed_s = rep_armed_r;
                    if (!rep_armed_r && (rep_cnt_r == REP_DLY_LAST)) begin
                        fire_s      = 1'b1;
                        rep_armed_s = 1'b1;
                        rep_cnt_s   = REP_ZERO;
                    end else if (rep_armed_r && (rep_cnt_r == REP_PER_LAST)) begin
                        fire_s    = 1'b1;
                        rep_cnt_s = REP_ZERO;
                    end else begin
                        rep_cnt_s = rep_cnt_r + REP_ONE;
                    end
                end else begin
                    rep_cnt_s   = REP_ZERO;
                    rep_armed_s = 1'b0;
                end
            end

            assign rep_fire_s = fire_s;
        end else begin : g_norep
            assign rep_fire_s = 1'b0;
        end
`else
        assign rep_fire_s = 1'b0;
`endif

        assign level_v_s[i] = level_r;
        assign rise_v_s[i]  = rise_r;
        assign fall_v_s[i]  = fall_r;
    end

    assign bus.btn_level = level_v_s;
    assign bus.btn_rise  = rise_v_s;
    assign bus.btn_fall  = fall_v_s;

endmodule
